leaf_packet_demux: RTL and testbench
====================================

LEAF_PACKET_DEMUX -- requirements
Module: leaf_packet_demux

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49: BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32: user data width.
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 5: leaf-address field width.
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4: port field width.
REQ-005 SHALL have parameter NUM_IN_PORTS, default 6: number of user-facing output channels.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16 (power of two): entries per channel.
REQ-007 SHALL have parameter LEAF_ID, default 0: this leaf's address.
REQ-008 SHALL have port clk, input, 1: the single clock.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port din_leaf_bft2interface, input, PACKET_BITS: incoming packet; no backpressure.
REQ-011 SHALL have port dout_leaf_interface2user, output, NUM_IN_PORTS*PAYLOAD_BITS: channel k data in slice k.
REQ-012 SHALL have port vld_interface2user, output, NUM_IN_PORTS: channel data valid.
REQ-013 SHALL have port ack_user2interface, input, NUM_IN_PORTS: consumer accept.
REQ-014 SHALL have port overflow, output, NUM_IN_PORTS: sticky per-channel drop-on-full flag.
REQ-015 SHALL have port drop_cnt, output, 16: count of packets discarded for any reason, saturating.

Function
REQ-016 SHALL decode packet fields as: bit 48 valid, [47:43] leaf, [42:39] port, [38:32] address (ignored), [31:0] payload.
REQ-017 SHALL ignore cycles where the valid bit is 0; these cycles SHALL NOT change any state.
REQ-018 SHALL route a valid packet with port p, 1<=p<=NUM_IN_PORTS, to channel p-1.
REQ-019 SHALL discard a valid packet with port 0 or port >NUM_IN_PORTS, and SHALL increment drop_cnt.
REQ-020 SHALL write the payload into the target channel FIFO in the arrival cycle.
REQ-021 SHALL assert vld at the earliest one cycle after the write into an empty FIFO; output data SHALL be registered.
REQ-022 SHALL treat vld&ack as a transfer and present the next entry the following cycle, giving one transfer per cycle per channel.
REQ-023 SHALL ignore ack while vld=0.
REQ-024 SHALL keep data stable while vld=1 and ack=0.
REQ-025 SHALL, when a channel is full and no read occurs that cycle, drop the packet, set overflow[k], and increment drop_cnt.
REQ-026 SHALL accept a write into a full channel when a transfer on that channel occurs in the same cycle.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH and distinguish full from empty with an extra pointer bit.
REQ-028 SHALL saturate drop_cnt at 16'hFFFF.
REQ-029 SHALL clear overflow only by reset.

Reset
REQ-030 SHALL, on reset assertion, immediately clear all FIFOs, vld, overflow, drop_cnt, and dout (0), regardless of clock.
REQ-031 SHALL discard in-flight data on reset mid-transfer; the first packet after deassertion SHALL be handled normally.

Configuration
REQ-032 SHALL, with LEAF_DEMUX_ADDR_CHECK_EN defined, discard valid packets whose leaf field != LEAF_ID and increment drop_cnt.
REQ-033 SHALL, without LEAF_DEMUX_ADDR_CHECK_EN, ignore the leaf field entirely.

Structure
REQ-034 SHALL take packet field offsets/widths and the packet struct typedef from the shared package leaf_pkt_pkg.
REQ-035 SHALL instantiate one sub-module leaf_port_fifo per channel: a FIFO with a registered output stage and a vld/ack interface.

Verification
REQ-036 Packet {v=1, port=2, payload=32'hDEADBEEF}, ack[1]=1: vld[1]=1 one cycle later with slice1=DEADBEEF, then 0.
REQ-037 17 packets to port 1 with ack=0: 16 stored, overflow[0]=1, drop_cnt=1; draining yields the 16 payloads in order.
REQ-038 Port=0 packet, then port=7 packet: no vld, drop_cnt=2.
REQ-039 Full channel 3 with simultaneous ack and new packet: no overflow; the new payload appears after the 16 older entries.
REQ-040 Macro defined, LEAF_ID=5, packet leaf=4: dropped, drop_cnt=1; leaf=5 delivered.
REQ-041 Reset asserted mid-cycle while vld=1: vld, overflow, and drop_cnt go to 0 without a clock edge.

Source files
------------

// File: rtl/leaf_pkt_pkg.sv
// Shared BFT packet layout for the leaf interface: field offsets, widths,
// the packed packet struct and a decode helper.
package leaf_pkt_pkg;

    localparam int PKT_W           = 49;
    localparam int PKT_VALID_BIT   = 48;
    localparam int PKT_LEAF_LSB    = 43;
    localparam int PKT_LEAF_W      = 5;
    localparam int PKT_PORT_LSB    = 39;
    localparam int PKT_PORT_W      = 4;
    localparam int PKT_ADDR_LSB    = 32;
    localparam int PKT_ADDR_W      = 7;
    localparam int PKT_PAYLOAD_LSB = 0;
    localparam int PKT_PAYLOAD_W   = 32;

    typedef struct packed {
        logic                     valid;
        logic [PKT_LEAF_W-1:0]    leaf;
        logic [PKT_PORT_W-1:0]    port;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } leaf_pkt_t;

    function automatic leaf_pkt_t unpack_pkt(input logic [PKT_W-1:0] raw);
        leaf_pkt_t p;
        p.valid   = raw[PKT_VALID_BIT];
        p.leaf    = raw[PKT_LEAF_LSB    +: PKT_LEAF_W];
        p.port    = raw[PKT_PORT_LSB    +: PKT_PORT_W];
        p.addr    = raw[PKT_ADDR_LSB    +: PKT_ADDR_W];
        p.payload = raw[PKT_PAYLOAD_LSB +: PKT_PAYLOAD_W];
        return p;
    endfunction

endpackage

// File: rtl/leaf_port_fifo.sv
// Per-channel FIFO with a registered head-of-queue output and vld/ack handshake.
// DEPTH must be a power of two >= 2; the output register mirrors the head entry.
module leaf_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ack,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic             rd, full, wr_acc, empty_nxt;
    logic [WIDTH-1:0] head_nxt;

    // vld always equals "not empty", so a transfer implies a stored entry
    assign rd     = vld && ack;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_acc = wr_en && (!full || rd);
    assign drop   = wr_en && full && !rd;

    assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd);
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

    // Next head may be the word being written this very cycle
    always_comb begin
        head_nxt = mem[rd_ptr_nxt[AW-1:0]];
        if (wr_acc && (rd_ptr_nxt == wr_ptr))
            head_nxt = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= 1'b0;
            data   <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            vld    <= !empty_nxt;
            if (!empty_nxt)
                data <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/leaf_packet_demux.sv
// Leaf-side BFT packet demultiplexer: routes payloads by port field into per-channel FIFOs.
// Optional leaf-address filtering is enabled by defining LEAF_DEMUX_ADDR_CHECK_EN.
module leaf_packet_demux
    import leaf_pkt_pkg::*;
#(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_IN_PORTS  = 6,
    parameter int FIFO_DEPTH    = 16,
    parameter int LEAF_ID       = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [PACKET_BITS-1:0]               din_leaf_bft2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    output logic [NUM_IN_PORTS-1:0]              vld_interface2user,
    input  logic [NUM_IN_PORTS-1:0]              ack_user2interface,
    output logic [NUM_IN_PORTS-1:0]              overflow,
    output logic [15:0]                          drop_cnt
);

    localparam logic [NUM_PORT_BITS-1:0] MAX_PORT  = NUM_PORT_BITS'(NUM_IN_PORTS);
    localparam logic [NUM_LEAF_BITS-1:0] LEAF_ADDR = NUM_LEAF_BITS'(LEAF_ID);

    leaf_pkt_t                   pkt;
    logic                        leaf_ok, route_ok, drop_inc;
    logic [NUM_IN_PORTS-1:0]     wr_en, ch_drop;
    logic [PKT_ADDR_W-1:0]       unused_addr;

    assign pkt         = unpack_pkt(din_leaf_bft2interface);
    assign unused_addr = pkt.addr;

`ifdef LEAF_DEMUX_ADDR_CHECK_EN
    assign leaf_ok = (pkt.leaf[NUM_LEAF_BITS-1:0] == LEAF_ADDR);
`else
    logic [NUM_LEAF_BITS-1:0] unused_leaf;
    assign unused_leaf = pkt.leaf[NUM_LEAF_BITS-1:0] ^ LEAF_ADDR;
    assign leaf_ok     = 1'b1;
`endif

    assign route_ok = pkt.valid && leaf_ok &&
                      (pkt.port != '0) && (pkt.port[NUM_PORT_BITS-1:0] <= MAX_PORT);

    // At most one packet arrives per cycle, so one increment covers every drop cause
    assign drop_inc = (pkt.valid && !route_ok) || (|ch_drop);

    for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_ch
        assign wr_en[k] = route_ok && (pkt.port[NUM_PORT_BITS-1:0] == NUM_PORT_BITS'(k + 1));

        leaf_port_fifo #(
            .WIDTH (PAYLOAD_BITS),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[k]),
            .wr_data (pkt.payload[PAYLOAD_BITS-1:0]),
            .ack     (ack_user2interface[k]),
            .vld     (vld_interface2user[k]),
            .data    (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .drop    (ch_drop[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= '0;
            drop_cnt <= '0;
        end else begin
            overflow <= overflow | ch_drop;
            if (drop_inc && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_leaf_packet_demux.sv
// Directed self-checking bench for leaf_packet_demux (LEAF_ID=5, six channels, depth 16).
module tb_leaf_packet_demux;

    logic         clk = 1'b0;
    logic         reset;
    logic [48:0]  din;
    logic [191:0] dout;
    logic [5:0]   vld;
    logic [5:0]   ack;
    logic [5:0]   overflow;
    logic [15:0]  drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_drop;

    leaf_packet_demux #(.LEAF_ID(5)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .din_leaf_bft2interface   (din),
        .dout_leaf_interface2user (dout),
        .vld_interface2user       (vld),
        .ack_user2interface       (ack),
        .overflow                 (overflow),
        .drop_cnt                 (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] mk(input logic [4:0] leaf, input logic [3:0] port,
                                       input logic [31:0] pl);
        return {1'b1, leaf, port, 7'h55, pl};
    endfunction

    function automatic logic [31:0] slice(input int k);
        return dout[k*32 +: 32];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        din   = '0;
        ack   = '0;
        exp_drop = 0;
        repeat (3) tick();
        chk("rst_vld",  64'(vld), 64'h0);
        chk("rst_ovf",  64'(overflow), 64'h0);
        chk("rst_drop", 64'(drop_cnt), 64'h0);
        chk("rst_dout", 64'(dout[63:0]), 64'h0);
        reset = 1'b0;
        tick();

        // Single packet to port 2 with consumer ready
        ack = 6'b000010;
        din = mk(5'd5, 4'd2, 32'hDEADBEEF);
        tick();
        din = '0;
        chk("p2_vld",  64'(vld), 64'h2);
        chk("p2_data", 64'(slice(1)), 64'hDEADBEEF);
        tick();
        chk("p2_vld_off", 64'(vld[1]), 64'h0);
        ack = '0;

        // Bad ports 0 and 7
        din = mk(5'd5, 4'd0, 32'h1);
        tick();
        din = mk(5'd5, 4'd7, 32'h2);
        tick();
        din = '0;
        exp_drop = 2;
        tick();
        chk("badport_vld",  64'(vld), 64'h0);
        chk("badport_drop", 64'(drop_cnt), 64'(exp_drop));

        // Invalid-bit cycle must not change anything
        din = {1'b0, 5'd5, 4'd1, 7'h0, 32'h777};
        tick();
        din = '0;
        tick();
        chk("inv_vld",  64'(vld), 64'h0);
        chk("inv_drop", 64'(drop_cnt), 64'(exp_drop));

        // Overflow on channel 0: 17 writes with no ack
        for (int i = 0; i < 17; i++) begin
            din = mk(5'd5, 4'd1, 32'h1000 + i);
            tick();
        end
        din = '0;
        exp_drop++;
        tick();
        chk("ovf_flag", 64'(overflow), 64'h1);
        chk("ovf_drop", 64'(drop_cnt), 64'(exp_drop));
        tick();
        chk("hold_data", 64'(slice(0)), 64'h1000);
        ack[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain0_vld%0d", i), 64'(vld[0]), 64'h1);
            chk($sformatf("drain0_dat%0d", i), 64'(slice(0)), 64'(32'h1000 + i));
            tick();
        end
        chk("drain0_empty", 64'(vld[0]), 64'h0);
        ack = '0;
        chk("ovf_sticky", 64'(overflow), 64'h1);

        // Full channel 2 accepts a write when a transfer happens the same cycle
        for (int i = 0; i < 16; i++) begin
            din = mk(5'd5, 4'd3, 32'h3000 + i);
            tick();
        end
        din = '0;
        chk("full3_ovf", 64'(overflow[2]), 64'h0);
        chk("full3_vld", 64'(vld[2]), 64'h1);
        ack[2] = 1'b1;
        din = mk(5'd5, 4'd3, 32'h3AAA);
        tick();
        din = '0;
        ack = '0;
        chk("simul_ovf",  64'(overflow), 64'h1);
        chk("simul_drop", 64'(drop_cnt), 64'(exp_drop));
        ack[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            e = (i < 15) ? 32'h3001 + i : 32'h3AAA;
            chk($sformatf("drain2_dat%0d", i), 64'(slice(2)), 64'(e));
            tick();
        end
        chk("drain2_empty", 64'(vld[2]), 64'h0);
        ack = '0;

        // Leaf field: filtered only when the address check is built in
        din = mk(5'd4, 4'd4, 32'h44);
        tick();
        din = '0;
`ifdef LEAF_DEMUX_ADDR_CHECK_EN
        exp_drop++;
        chk("leaf4_vld",  64'(vld[3]), 64'h0);
        chk("leaf4_drop", 64'(drop_cnt), 64'(exp_drop));
`else
        chk("leaf4_vld",  64'(vld[3]), 64'h1);
        chk("leaf4_data", 64'(slice(3)), 64'h44);
        ack[3] = 1'b1;
        tick();
        ack = '0;
        chk("leaf4_drop", 64'(drop_cnt), 64'(exp_drop));
`endif
        din = mk(5'd5, 4'd4, 32'h55);
        tick();
        din = '0;
        chk("leaf5_vld",  64'(vld[3]), 64'h1);
        chk("leaf5_data", 64'(slice(3)), 64'h55);
        ack[3] = 1'b1;
        tick();
        ack = '0;
        chk("leaf5_off", 64'(vld[3]), 64'h0);

        // Asynchronous reset mid-cycle while a channel is valid
        din = mk(5'd5, 4'd5, 32'h5555);
        tick();
        din = '0;
        chk("pre_rst_vld", 64'(vld[4]), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_vld",  64'(vld), 64'h0);
        chk("arst_ovf",  64'(overflow), 64'h0);
        chk("arst_drop", 64'(drop_cnt), 64'h0);
        chk("arst_dout", 64'(dout[159:128]), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        din = mk(5'd5, 4'd6, 32'h6666);
        tick();
        din = '0;
        chk("post_rst_vld",  64'(vld), 64'h20);
        chk("post_rst_data", 64'(slice(5)), 64'h6666);
        chk("post_rst_drop", 64'(drop_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
